// File: rtl/spi_rx_fifo.sv
// spi_rx_fifo: serial word receiver with a show-ahead receive FIFO.
// Shifts in one bit per accepted clk edge, MSB- or LSB-first, and presents
// the last completed word on a stable register. Every completed word is also
// queued for a downstream consumer.
// Optional feature: define SPI_RX_PARITY_EN to expect one even-parity bit
// after each word and report it on parity_err.
module spi_rx_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          din,
  input  logic                          bit_en,
  input  logic                          lsb_first,
  input  logic                          flush,
  output logic [DATA_W-1:0]             word,
  output logic                          word_valid,
  input  logic                          rd_en,
  output logic [DATA_W-1:0]             rd_data,
  output logic                          empty,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          overflow
`ifdef SPI_RX_PARITY_EN
  ,
  output logic                          parity_err
`endif
);

`ifdef SPI_RX_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif
  localparam int NBITS = DATA_W + PAR_BITS;
  localparam int BC_W  = $clog2(NBITS + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [BC_W-1:0]  LAST_C  = BC_W'(NBITS - 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  logic [DATA_W-1:0] sh;
  logic [DATA_W-1:0] sh_next;
  logic [DATA_W-1:0] word_next;
  logic [BC_W-1:0]   bit_cnt;
  logic              order_lsb;
  logic              lsb_eff;
  logic              accept;
  logic              complete;
  logic              push;
  logic              pop;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;

`ifdef SPI_RX_PARITY_EN
  logic par;
`endif

  // Bit acceptance, effective ordering, next shift value and completion.
  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    accept    = bit_en && !flush;
    lsb_eff   = (bit_cnt == '0) ? lsb_first : order_lsb;
    sh_next   = lsb_eff ? {din, sh[DATA_W-1:1]} : {sh[DATA_W-2:0], din};
    complete  = accept && (bit_cnt == LAST_C);
`ifdef SPI_RX_PARITY_EN
    word_next = sh;        // last accepted bit is parity, not data
`else
    word_next = sh_next;   // last accepted bit is the final data bit
`endif
  end

  // Shift register, bit counter and latched bit ordering.
  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh        <= '0;
      bit_cnt   <= '0;
      order_lsb <= 1'b0;
`ifdef SPI_RX_PARITY_EN
      par       <= 1'b0;
`endif
    end else if (flush) begin
      sh      <= '0;
      bit_cnt <= '0;
`ifdef SPI_RX_PARITY_EN
      par     <= 1'b0;
`endif
    end else if (bit_en) begin
      order_lsb <= lsb_eff;
      bit_cnt   <= complete ? '0 : bit_cnt + 1'b1;
`ifdef SPI_RX_PARITY_EN
      if (!complete) sh <= sh_next;
      par <= complete ? 1'b0 : (par ^ din);
`else
      sh <= sh_next;
`endif
    end
  end

  // Output word register and its one-cycle valid pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word       <= '0;
      word_valid <= 1'b0;
`ifdef SPI_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      word_valid <= complete;
      if (complete) begin
        word <= word_next;
`ifdef SPI_RX_PARITY_EN
        parity_err <= par ^ din;
`endif
      end
    end
  end

  // FIFO handshake: a push at full is allowed only when a pop frees the slot.
  always_comb begin
    empty   = (count == '0);
    full    = (count == DEPTH_C);
    pop     = rd_en && !empty;
    push    = complete && (!full || pop);
    rd_data = empty ? '0 : mem[rd_ptr];
  end

  // FIFO storage, written on push.
  // NOTE: storage is not reset; occupancy and pointers define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= word_next;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sticky overflow: a completed word was dropped; cleared by flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                  overflow <= 1'b0;
    else if (flush)                           overflow <= 1'b0;
    else if (complete && full && !pop)        overflow <= 1'b1;
  end

endmodule

// File: tb/tb_spi_rx_fifo.sv
// Directed testbench for spi_rx_fifo (default build, DATA_W=8, FIFO_DEPTH=4).
module tb_spi_rx_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       din;
  logic       bit_en;
  logic       lsb_first;
  logic       flush;
  logic [7:0] word;
  logic       word_valid;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       empty;
  logic       full;
  logic [2:0] count;
  logic       overflow;

  int total  = 0;
  int passed = 0;
  int fails  = 0;

  spi_rx_fifo #(.DATA_W(8), .FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .bit_en     (bit_en),
    .lsb_first  (lsb_first),
    .flush      (flush),
    .word       (word),
    .word_valid (word_valid),
    .rd_en      (rd_en),
    .rd_data    (rd_data),
    .empty      (empty),
    .full       (full),
    .count      (count),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    din    = b;
    bit_en = 1'b1;
    tick();
    bit_en = 1'b0;
  endtask

  // Send one full word; rd_last raises rd_en on the completing edge only.
  task automatic send_word(input logic [7:0] w, input logic lsb, input logic rd_last);
    lsb_first = lsb;
    for (int i = 0; i < 8; i++) begin
      din    = lsb ? w[i] : w[7-i];
      bit_en = 1'b1;
      rd_en  = rd_last && (i == 7);
      tick();
    end
    bit_en = 1'b0;
    rd_en  = 1'b0;
  endtask

  task automatic pop_one();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; din = 1'b0; bit_en = 1'b0; lsb_first = 1'b0; flush = 1'b0; rd_en = 1'b0;
    #12;
    check("rst_word",     word, 0);
    check("rst_valid",    word_valid, 0);
    check("rst_empty",    empty, 1);
    check("rst_full",     full, 0);
    check("rst_count",    count, 0);
    check("rst_overflow", overflow, 0);
    check("rst_rd_data",  rd_data, 0);
    rst = 1'b0;
    tick();

    // MSB-first 8'hCA: 1,1,0,0,1,0,1,0
    send_bit(1); send_bit(1); send_bit(0); send_bit(0);
    send_bit(1); send_bit(0); send_bit(1);
    check("msb_word_before", word, 0);
    check("msb_valid_before", word_valid, 0);
    send_bit(0);
    check("msb_word",    word, 8'hCA);
    check("msb_valid",   word_valid, 1);
    check("msb_count",   count, 1);
    check("msb_rd_data", rd_data, 8'hCA);
    check("msb_empty",   empty, 0);
    tick();
    check("msb_valid_one_cycle", word_valid, 0);
    pop_one();
    check("pop_empty",   empty, 1);
    check("pop_rd_data", rd_data, 0);

    // LSB-first 8'hCA: 0,1,0,1,0,0,1,1 with lsb_first dropped after bit 3
    lsb_first = 1'b1;
    send_bit(0); send_bit(1); send_bit(0);
    lsb_first = 1'b0;
    send_bit(1); send_bit(0); send_bit(0); send_bit(1); send_bit(1);
    check("lsb_word",    word, 8'hCA);
    check("lsb_rd_data", rd_data, 8'hCA);
    pop_one();

    // Partial word, 10-cycle flush, then 8'hA7
    send_bit(1); send_bit(1); send_bit(1); send_bit(1); send_bit(1);
    flush = 1'b1; bit_en = 1'b1; din = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("flush_word_hold", word, 8'hCA);
    end
    check("flush_no_valid", word_valid, 0);
    flush = 1'b0; bit_en = 1'b0;
    send_word(8'hA7, 1'b0, 1'b0);
    check("post_flush_word", word, 8'hA7);
    check("post_flush_ovf",  overflow, 0);
    check("post_flush_count", count, 1);

    // 8'h3F with a 3-cycle bit_en gap between bits 4 and 5
    send_bit(0); send_bit(0); send_bit(1); send_bit(1);
    din = 1'b0;
    tick(); tick(); tick();
    send_bit(1); send_bit(1); send_bit(1); send_bit(1);
    check("gap_word",  word, 8'h3F);
    check("gap_count", count, 2);
    check("gap_head",  rd_data, 8'hA7);
    pop_one();
    check("gap_head2", rd_data, 8'h3F);
    pop_one();
    check("gap_drained", empty, 1);

    // Overflow: five words, no reads
    send_word(8'h11, 1'b0, 1'b0);
    send_word(8'h22, 1'b0, 1'b0);
    send_word(8'h33, 1'b0, 1'b0);
    send_word(8'h44, 1'b0, 1'b0);
    check("four_full",  full, 1);
    check("four_count", count, 4);
    check("four_ovf",   overflow, 0);
    send_word(8'h55, 1'b0, 1'b0);
    check("five_word",  word, 8'h55);
    check("five_count", count, 4);
    check("five_ovf",   overflow, 1);
    check("five_head",  rd_data, 8'h11);

    // Push plus pop at full
    send_word(8'h66, 1'b0, 1'b1);
    check("pp_count", count, 4);
    check("pp_ovf",   overflow, 1);
    check("pp_head",  rd_data, 8'h22);
    check("pp_word",  word, 8'h66);

    // Flush clears overflow but leaves word and FIFO
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_ovf_clr", overflow, 0);
    check("flush_count",   count, 4);
    check("flush_word",    word, 8'h66);

    // Drain in order
    pop_one(); check("drain_33", rd_data, 8'h33);
    pop_one(); check("drain_44", rd_data, 8'h44);
    pop_one(); check("drain_66", rd_data, 8'h66);
    pop_one();
    check("drain_empty", empty, 1);
    check("drain_count", count, 0);
    pop_one();
    check("pop_on_empty", count, 0);

    // Push with rd_en at count=0: pop ignored
    send_word(8'h77, 1'b0, 1'b1);
    check("p0_count", count, 1);
    check("p0_head",  rd_data, 8'h77);

    // Reset mid-word, then a full word 8'h5A
    send_bit(1); send_bit(0); send_bit(1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_word",  word, 0);
    check("mid_rst_count", count, 0);
    check("mid_rst_empty", empty, 1);
    check("mid_rst_rd",    rd_data, 0);
    check("mid_rst_valid", word_valid, 0);
    rst = 1'b0;
    tick();
    send_word(8'h5A, 1'b0, 1'b0);
    check("after_rst_word",  word, 8'h5A);
    check("after_rst_count", count, 1);
    check("after_rst_head",  rd_data, 8'h5A);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/spi_rx_fifo.md
Name: spi_rx_fifo

Overview:
Parametrised successor to the serial byte receiver. Shifts in one serial bit per qualified rising clk edge, assembles DATA_W-bit words in MSB-first or LSB-first order, and holds the last completed word on a stable output. Every completed word is also pushed into a small show-ahead receive FIFO, so a downstream consumer can drain several words at its own pace. Sits between the serial link pins and the register/bus side of the design.

Parameters:
DATA_W, 8, word width in bits (>= 2)
FIFO_DEPTH, 4, receive FIFO entries (power of 2, >= 2)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous reset, active-high
din  input  1  serial data bit
bit_en  input  1  din is sampled only on edges where bit_en=1
lsb_first  input  1  0 = first bit is MSB, 1 = first bit is LSB
flush  input  1  discard the partial word, level-sensitive
word  output  DATA_W  last completed word, registered
word_valid  output  1  one-cycle pulse, high in the cycle after a word completes
rd_en  input  1  pop the FIFO head
rd_data  output  DATA_W  FIFO head, show-ahead; 0 when empty
empty  output  1  FIFO empty
full  output  1  FIFO full
count  output  $clog2(FIFO_DEPTH)+1  FIFO occupancy
overflow  output  1  sticky: a completed word was dropped because the FIFO was full

Behaviour:
- rst=1, asynchronous: shift register=0, bit counter=0, word=0, word_valid=0, FIFO empty (count=0), overflow=0, parity_err=0.
- Accepted bit: rising clk edge with bit_en=1 and flush=0. On any other edge the shift state holds.
- Bit ordering is latched from lsb_first on the first accepted bit of each word (counter=0). Changes to lsb_first mid-word have no effect.
- MSB-first: shift register <= {sh[DATA_W-2:0], din}. LSB-first: shift register <= {din, sh[DATA_W-1:1]}.
- Completion: the accepted bit that brings the counter to DATA_W. On that edge, word <= assembled value including the current din, and the counter returns to 0. word_valid=1 for exactly the next cycle.
- word changes only on completion. It holds across flush and bit_en gaps.
- flush=1 on an edge: counter=0 and shift register=0. word and the FIFO are untouched, and overflow is cleared. If flush coincides with what would be the completing bit, flush wins: no completion and no push.
- FIFO push happens on every completion; rd_data/empty/full/count update one cycle later.
- rd_en pops the head when empty=0. rd_en on an empty FIFO is ignored, with no error.
- Completion while full:
  - with rd_en=1 in the same cycle, the pop and push both occur and count stays FIFO_DEPTH;
  - otherwise the new word is dropped from the FIFO, word still updates, and overflow <= 1.
- Simultaneous push and pop at count=0: the push occurs and the pop is ignored.
- Reset asserted mid-word discards the partial word immediately.
- Pointers wrap modulo FIFO_DEPTH. count ranges 0..FIFO_DEPTH.

Optional Feature:
- Macro: SPI_RX_PARITY_EN.
- When defined:
  - each word is followed by one even-parity bit. Completion occurs on accepted bit number DATA_W+1, and the parity bit is not stored.
  - output parity_err (1 bit, registered) updates at each completion: 1 if XOR(data bits, parity bit) != 0, else 0. It is reset to 0.
  - words with bad parity are still written to word and pushed.
  - flush clears the parity state but not parity_err.
- When undefined: no parity_err port, and completion occurs on bit DATA_W.

Test Plan:
- MSB-first, bit_en=1, din sequence 1,1,0,0,1,0,1,0 -> word=8'hCA and word_valid pulses once after the 8th edge; word=0 before that; rd_data=8'hCA, count=1.
- LSB-first, din sequence 0,1,0,1,0,0,1,1 -> word=8'hCA. Toggling lsb_first after bit 3 does not change the result.
- 5 bits sent, then flush for 10 cycles, then 1,0,1,0,0,1,1,1 -> word holds 8'hCA throughout the flush, then becomes 8'hA7 after the 8th post-flush bit; overflow unaffected.
- bit_en low for 3 cycles between bits 4 and 5 of 8'h3F -> word=8'h3F; the idle cycles add no bits.
- FIFO_DEPTH=4, 5 words sent with no reads -> full=1, count=4, overflow=1, word=5th word, pops return words 1-4 in order then empty=1. A pop plus push at full keeps count=4 and overflow unchanged.
- rst pulsed mid-word (after 3 bits), then 8 full bits -> all outputs are 0 right after reset, and the following word assembles correctly from bit 1.
